epmp_alu_seq: RTL and testbench

EPMP_ALU_SEQ -- requirements
Module: epmp_alu_seq

---
 rtl/epmp_alu_seq.sv | 119 +++++++++++
 tb/tb_epmp_alu_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/epmp_alu_seq.sv
// Request/response sequencer driving a bus-attached 8-bit ALU.
// Ports: req_* in, rsp_* out, ALU_En/ACC_Out_En/ALU_Cmd/ACC_bus/C to the ALU, op_count.
module epmp_alu_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [7:0]       req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_c,
  output logic             rsp_err,
  output logic             ALU_En,
  output logic             ACC_Out_En,
  output logic [3:0]       ALU_Cmd,
  inout  wire  [7:0]       ACC_bus,
  input  logic             C,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    READ,
    RESP
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_LOAD = 4'd8;

  state_t     state;
  state_t     nxt;
  logic [3:0] op_q;
  logic [7:0] data_q;
  logic       accept;
  logic       legal;
  logic       opnd;
  logic       drv;

  assign accept = req_valid & req_ready;
  assign legal  = (req_op <= OP_LOAD);

  // Only operand-carrying commands put data on the bus.
  assign opnd = (op_q == OP_ADD) | (op_q == OP_SUB) |
                (op_q == OP_AND) | (op_q == OP_OR)  |
                (op_q == OP_LOAD);

  assign drv     = (state == EXEC) & opnd;
  assign ACC_bus = drv ? data_q : 8'hzz;

  always_comb begin
    nxt        = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    ALU_En     = 1'b0;
    ACC_Out_En = 1'b0;
    ALU_Cmd    = 4'd0;
    unique case (1'b1)
      (state == IDLE): begin
        req_ready = 1'b1;
        if (accept)
          nxt = legal ? EXEC : RESP;
      end
      (state == EXEC): begin
        ALU_En  = 1'b1;
        ALU_Cmd = op_q;
        nxt     = READ;
      end
      (state == READ): begin
        ACC_Out_En = 1'b1;
        ALU_Cmd    = op_q;
        nxt        = RESP;
      end
      (state == RESP): begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      op_q     <= 4'd0;
      data_q   <= 8'd0;
      rsp_data <= 8'd0;
      rsp_c    <= 1'b0;
      rsp_err  <= 1'b0;
      op_count <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        op_q    <= req_op;
        data_q  <= req_data;
        rsp_err <= ~legal;
        if (!legal) begin
          rsp_data <= 8'd0;
          rsp_c    <= 1'b0;
        end
      end
      if (state == READ) begin
        rsp_data <= ACC_bus;
        rsp_c    <= C;
      end
      if ((state == RESP) && rsp_ready && !rsp_err)
        op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_epmp_alu_seq.sv
// Directed bench for epmp_alu_seq with a behavioural bus-attached ALU.
// Vector table plus hand-written stall and mid-operation reset sequences.
module tb_epmp_alu_seq;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [7:0]  req_data = 8'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic        rsp_c;
  logic        rsp_err;
  logic        ALU_En;
  logic        ACC_Out_En;
  logic [3:0]  ALU_Cmd;
  wire  [7:0]  ACC_bus;
  logic        C;
  logic [15:0] op_count;

  logic [7:0]  alu_acc = 8'd0;
  logic        alu_c = 1'b0;
  logic        probe_en = 1'b0;
  int          en_cnt = 0;
  int          out_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          exp_cnt = 0;

  always #5 clk = ~clk;

  epmp_alu_seq #(.CNT_W(16)) dut (
    .clk(clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_c(rsp_c), .rsp_err(rsp_err),
    .ALU_En(ALU_En), .ACC_Out_En(ACC_Out_En), .ALU_Cmd(ALU_Cmd),
    .ACC_bus(ACC_bus), .C(C), .op_count(op_count)
  );

  assign C = alu_c;
  assign ACC_bus = ACC_Out_En ? alu_acc : 8'hzz;
  // Probe pattern: reads back as 5A only when the sequencer releases the bus.
  assign ACC_bus = probe_en ? 8'h5A : 8'hzz;

  always @(posedge clk) begin
    if (ALU_En) begin
      en_cnt <= en_cnt + 1;
      case (ALU_Cmd)
        4'd0: {alu_c, alu_acc} <= {1'b0, alu_acc} + {1'b0, ACC_bus};
        4'd1: {alu_c, alu_acc} <= {1'b0, alu_acc} - {1'b0, ACC_bus};
        4'd2: {alu_c, alu_acc} <= 9'd0;
        4'd3: {alu_c, alu_acc} <= {1'b0, 8'd0 - alu_acc};
        4'd4: {alu_c, alu_acc} <= {1'b0, alu_acc} + 9'd1;
        4'd5: {alu_c, alu_acc} <= {1'b0, alu_acc} - 9'd1;
        4'd6: {alu_c, alu_acc} <= {1'b0, alu_acc & ACC_bus};
        4'd7: {alu_c, alu_acc} <= {1'b0, alu_acc | ACC_bus};
        4'd8: {alu_c, alu_acc} <= {1'b0, ACC_bus};
        default: ;
      endcase
    end
    if (ACC_Out_En)
      out_cnt <= out_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic [3:0] op, input logic [7:0] d,
                       input logic [7:0] ed, input logic ec,
                       input logic ee, input int stall);
    int to;
    int lat;
    int en0;
    int out0;
    logic has_d;
    has_d = (op == 4'd0) || (op == 4'd1) || (op == 4'd6) ||
            (op == 4'd7) || (op == 4'd8);
    to = 0;
    while (!req_ready && to < 20) begin
      @(negedge clk);
      to++;
    end
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    en0  = en_cnt;
    out0 = out_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (!ee && has_d) begin
      check("bus_operand", {24'd0, ACC_bus}, {24'd0, d});
    end else begin
      probe_en = 1'b1;
      #1;
      check("bus_released", {24'd0, ACC_bus}, 32'h5A);
      probe_en = 1'b0;
    end
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, ee ? 32'd1 : 32'd3);
    check("rsp_data", {24'd0, rsp_data}, {24'd0, ed});
    check("rsp_c", {31'd0, rsp_c}, {31'd0, ec});
    check("rsp_err", {31'd0, rsp_err}, {31'd0, ee});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = 4'd8;
      req_data  = 8'h11;
      #1;
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_ready", {31'd0, req_ready}, 32'd0);
      check("stall_data", {24'd0, rsp_data}, {24'd0, ed});
      check("stall_c", {31'd0, rsp_c}, {31'd0, ec});
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    if (!ee)
      exp_cnt++;
    check("idle_after_hs", {31'd0, req_ready}, 32'd1);
    check("op_count", {16'd0, op_count}, exp_cnt);
    check("alu_en_pulses", en_cnt - en0, ee ? 32'd0 : 32'd1);
    check("acc_out_pulses", out_cnt - out0, ee ? 32'd0 : 32'd1);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] d;
    logic [7:0] ed;
    logic       ec;
    logic       ee;
    int         stall;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'd8, 8'h3C, 8'h3C, 1'b0, 1'b0, 0};
    vecs[1]  = '{4'd8, 8'hFF, 8'hFF, 1'b0, 1'b0, 0};
    vecs[2]  = '{4'd4, 8'hC3, 8'h00, 1'b1, 1'b0, 0};
    vecs[3]  = '{4'd8, 8'hF0, 8'hF0, 1'b0, 1'b0, 0};
    vecs[4]  = '{4'd0, 8'h20, 8'h10, 1'b1, 1'b0, 0};
    vecs[5]  = '{4'd1, 8'h30, 8'hE0, 1'b1, 1'b0, 0};
    vecs[6]  = '{4'd6, 8'h0F, 8'h00, 1'b0, 1'b0, 0};
    vecs[7]  = '{4'd7, 8'hA5, 8'hA5, 1'b0, 1'b0, 0};
    vecs[8]  = '{4'd3, 8'hC3, 8'h5B, 1'b0, 1'b0, 0};
    vecs[9]  = '{4'd5, 8'hC3, 8'h5A, 1'b0, 1'b0, 0};
    vecs[10] = '{4'd2, 8'hC3, 8'h00, 1'b0, 1'b0, 0};
    vecs[11] = '{4'd5, 8'hC3, 8'hFF, 1'b1, 1'b0, 0};
    vecs[12] = '{4'd8, 8'h77, 8'h77, 1'b0, 1'b0, 5};
    vecs[13] = '{4'hC, 8'h3C, 8'h00, 1'b0, 1'b1, 0};
    vecs[14] = '{4'h9, 8'hFF, 8'h00, 1'b0, 1'b1, 0};
    vecs[15] = '{4'hF, 8'hFF, 8'h00, 1'b0, 1'b1, 0};

    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_alu_en", {31'd0, ALU_En}, 32'd0);
    check("rst_acc_out", {31'd0, ACC_Out_En}, 32'd0);
    check("rst_op_count", {16'd0, op_count}, 32'd0);
    probe_en = 1'b1;
    #1;
    check("rst_bus", {24'd0, ACC_bus}, 32'h5A);
    probe_en = 1'b0;
    @(negedge clk);
    Reset = 1'b0;

    for (int i = 0; i < 16; i++)
      do_op(vecs[i].op, vecs[i].d, vecs[i].ed, vecs[i].ec,
            vecs[i].ee, vecs[i].stall);

    // Reset during EXEC discards the operation.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 4'd8;
    req_data  = 8'h99;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("exec_alu_en", {31'd0, ALU_En}, 32'd1);
    #1;
    Reset = 1'b1;
    #1;
    check("mrst_alu_en", {31'd0, ALU_En}, 32'd0);
    check("mrst_acc_out", {31'd0, ACC_Out_En}, 32'd0);
    check("mrst_op_count", {16'd0, op_count}, 32'd0);
    probe_en = 1'b1;
    #1;
    check("mrst_bus", {24'd0, ACC_bus}, 32'h5A);
    probe_en = 1'b0;
    @(negedge clk);
    Reset = 1'b0;
    exp_cnt = 0;
    #1;
    check("mrst_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    do_op(4'd8, 8'h3C, 8'h3C, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
